// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/rdy handshake,
// holds each instruction until acknowledged, applies redirects and flags memory timeouts.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_rdy,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      inst,
  output logic             inst_valid,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  input  logic             inst_ack,
  input  logic             redirect_en,
  input  logic [31:0]      redirect_pc,
  output logic             fetch_err,
  output logic [CNT_W-1:0] fetch_cnt
);

  // Wait counter only ever reaches TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0]       pc_inc;

  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    wait_d       = wait_q;
    case (state_q)
      S_REQ: begin
        // A response arriving on the timeout cycle still counts as a normal fetch.
        if (imem_rdy) begin
          inst_d       = imem_rdata;
          inst_valid_d = 1'b1;
          wait_d       = '0;
          state_d      = S_HOLD;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_HOLD: begin
        if (inst_ack) begin
          inst_valid_d = 1'b0;
          cnt_d        = cnt_q + CNT_W'(1);
          pc_d         = redirect_en ? (redirect_pc & 32'hFFFF_FFFC) : pc_inc;
          state_d      = S_REQ;
        end
      end
      S_ERR: begin
        inst_valid_d = 1'b0;
        err_d        = 1'b1;
      end
      default: begin
        state_d = S_ERR;
        err_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      wait_q       <= wait_d;
    end
  end

  assign imem_req   = (state_q == S_REQ);
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_inc;
  assign fetch_err  = err_q;
  assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus pushes expected {pc, inst} pairs,
// a monitor pops and compares each time a new instruction is presented.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rdy;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic        inst_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        inst_ack;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        fetch_err;
   logic [31:0] fetch_cnt;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] expQ[$];
   logic        seen  = 1'b0;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
      .inst(inst), .inst_valid(inst_valid),
      .pc(pc), .pc_plus4(pc_plus4),
      .inst_ack(inst_ack), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
      .fetch_err(fetch_err), .fetch_cnt(fetch_cnt)
   );

   always #5 clk = ~clk;

   // Monitor: each rising inst_valid is one delivered instruction to score.
   always @(negedge clk) begin
      logic [63:0] e;
      if (!rst_n) begin
         seen = 1'b0;
      end else if (inst_valid && !seen) begin
         seen = 1'b1;
         total++;
         if (expQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_empty: got pc=%h inst=%h, expected nothing", pc, inst);
         end else begin
            e = expQ.pop_front();
            if ({pc, inst} !== e) begin
               bad++;
               $display("[TB] FAIL scoreboard: got pc=%h inst=%h, expected pc=%h inst=%h",
                        pc, inst, e[63:32], e[31:0]);
            end
         end
      end else if (!inst_valid) begin
         seen = 1'b0;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Memory answers after lat request cycles; called on a negedge while in S_REQ.
   task automatic applyStimulus(input int lat, input logic [31:0] data, input logic [31:0] expPc);
      for (int i = 0; i < lat; i++) begin
         checkOutput("req_high", {31'd0, imem_req}, 32'd1);
         checkOutput("req_addr", imem_addr, expPc);
         checkOutput("no_valid_while_req", {31'd0, inst_valid}, 32'd0);
         checkOutput("no_err_while_req", {31'd0, fetch_err}, 32'd0);
         if (i == lat - 1) begin
            imem_rdy   = 1'b1;
            imem_rdata = data;
            expQ.push_back({expPc, data});
         end
         @(posedge clk);
         @(negedge clk);
      end
      imem_rdy   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      checkOutput("req_low_in_hold", {31'd0, imem_req}, 32'd0);
   endtask

   task automatic ackInst(input logic redir, input logic [31:0] rpc);
      inst_ack    = 1'b1;
      redirect_en = redir;
      redirect_pc = rpc;
      @(posedge clk);
      @(negedge clk);
      inst_ack    = 1'b0;
      redirect_en = 1'b0;
      redirect_pc = 32'h0;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      imem_rdy    = 1'b0;
      imem_rdata  = 32'h0;
      inst_ack    = 1'b0;
      redirect_en = 1'b0;
      redirect_pc = 32'h0;
      @(negedge clk);
      doReset();
      checkOutput("rst_req", {31'd0, imem_req}, 32'd1);
      checkOutput("rst_addr", imem_addr, 32'h0);
      checkOutput("rst_valid", {31'd0, inst_valid}, 32'd0);
      checkOutput("rst_cnt", fetch_cnt, 32'd0);
      checkOutput("rst_err", {31'd0, fetch_err}, 32'd0);
      checkOutput("rst_inst", inst, 32'h0);

      // Zero-latency fetch then sequential ack.
      applyStimulus(1, 32'h2008_0005, 32'h0);
      checkOutput("hold_pc_plus4", pc_plus4, 32'h4);
      ackInst(1'b0, 32'h0);
      checkOutput("seq_addr", imem_addr, 32'h4);
      checkOutput("seq_cnt", fetch_cnt, 32'd1);
      checkOutput("seq_valid_cleared", {31'd0, inst_valid}, 32'd0);

      // Three-cycle memory latency, then redirect without ack is ignored.
      applyStimulus(3, 32'h8C01_0000, 32'h4);
      inst_ack    = 1'b0;
      redirect_en = 1'b1;
      redirect_pc = 32'h0000_0100;
      @(posedge clk);
      @(negedge clk);
      redirect_en = 1'b0;
      checkOutput("noack_pc", pc, 32'h4);
      checkOutput("noack_valid", {31'd0, inst_valid}, 32'd1);
      checkOutput("noack_inst", inst, 32'h8C01_0000);
      ackInst(1'b1, 32'h0000_0043);
      checkOutput("redir_addr", imem_addr, 32'h0000_0040);
      checkOutput("redir_cnt", fetch_cnt, 32'd2);

      // Redirect to the top word, then wrap to zero.
      applyStimulus(1, 32'h0800_0000, 32'h0000_0040);
      ackInst(1'b1, 32'hFFFF_FFFF);
      checkOutput("top_addr", imem_addr, 32'hFFFF_FFFC);
      applyStimulus(2, 32'h1234_5678, 32'hFFFF_FFFC);
      checkOutput("wrap_pc_plus4", pc_plus4, 32'h0);
      ackInst(1'b0, 32'h0);
      checkOutput("wrap_addr", imem_addr, 32'h0);
      checkOutput("wrap_cnt", fetch_cnt, 32'd4);

      // Response on the 16th waiting cycle still completes normally.
      applyStimulus(16, 32'hAAAA_5555, 32'h0);
      checkOutput("late_rdy_err", {31'd0, fetch_err}, 32'd0);
      ackInst(1'b0, 32'h0);
      checkOutput("late_rdy_addr", imem_addr, 32'h4);
      checkOutput("late_rdy_cnt", fetch_cnt, 32'd5);

      // No response for 16 cycles: sticky error.
      repeat (15) @(posedge clk);
      @(negedge clk);
      checkOutput("pre_timeout_err", {31'd0, fetch_err}, 32'd0);
      checkOutput("pre_timeout_req", {31'd0, imem_req}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      checkOutput("timeout_err", {31'd0, fetch_err}, 32'd1);
      checkOutput("timeout_req", {31'd0, imem_req}, 32'd0);
      imem_rdy   = 1'b1;
      imem_rdata = 32'h5555_AAAA;
      inst_ack   = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      imem_rdy = 1'b0;
      inst_ack = 1'b0;
      checkOutput("err_sticky", {31'd0, fetch_err}, 32'd1);
      checkOutput("err_no_valid", {31'd0, inst_valid}, 32'd0);
      checkOutput("err_cnt_frozen", fetch_cnt, 32'd5);

      // Reset clears the error and restarts from RESET_PC.
      doReset();
      checkOutput("rerst_err", {31'd0, fetch_err}, 32'd0);
      checkOutput("rerst_addr", imem_addr, 32'h0);
      checkOutput("rerst_cnt", fetch_cnt, 32'd0);
      applyStimulus(1, 32'h0000_0013, 32'h0);
      ackInst(1'b0, 32'h0);
      checkOutput("rerst_seq_addr", imem_addr, 32'h4);

      // Reset in the middle of a pending request; late rdy answers the new request.
      repeat (2) @(posedge clk);
      @(negedge clk);
      doReset();
      checkOutput("midreq_addr", imem_addr, 32'h0);
      checkOutput("midreq_cnt", fetch_cnt, 32'd0);
      applyStimulus(1, 32'hCAFE_0001, 32'h0);
      ackInst(1'b0, 32'h0);
      checkOutput("midreq_next_addr", imem_addr, 32'h4);

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("scoreboard_drained", expQ.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
